// File: rtl/branch_unit.sv
// Branch execution unit: runs B, BL, BX and BLX(reg) as a short sequence of
// register-file reads and writes through one read port and one write port.
module branch_unit #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 4,
   parameter int unsigned OFFSET_W = 24,
   parameter int unsigned PC_REG   = 15,
   parameter int unsigned LR_REG   = 14,
   parameter int unsigned PREFETCH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                cond_i,
   input  logic                link_i,
   input  logic                exchange_i,
   input  logic                thumb_i,
   input  logic [OFFSET_W-1:0] offset_i,
   input  logic [REG_AW-1:0]   rm_i,
   output logic                read_en_o,
   output logic [REG_AW-1:0]   read_reg_o,
   input  logic [DATA_W-1:0]   read_value_i,
   output logic                write_en_o,
   output logic [REG_AW-1:0]   write_reg_o,
   output logic [DATA_W-1:0]   write_value_o,
   output logic                t_we_o,
   output logic                t_value_o,
   output logic                busy_o,
   output logic                done_o
);

   typedef enum logic [2:0] {
      StIdle, StRpc, StWpc, StRrm, StWrm, StWlr, StWrpc, StDone
   } state_e;

   state_e                state_q, state_d;
   logic                  cond_q, link_q, exch_q, thumb_q;
   logic [OFFSET_W-1:0]   offset_q;
   logic [REG_AW-1:0]     rm_idx_q;
   logic [DATA_W-1:0]     pc_q, rm_q;

   logic                  taken_exch;
   logic [DATA_W-1:0]     step, pf, off_ext, off_sh, ret_addr, target;

   assign taken_exch = cond_q & exch_q;

   // Address arithmetic derived from the latched operands (modulo 2^DATA_W).
   always_comb begin
      step     = thumb_q ? DATA_W'(2) : DATA_W'(4);
      pf       = thumb_q ? DATA_W'(PREFETCH / 2) : DATA_W'(PREFETCH);
      off_ext  = {{(DATA_W - OFFSET_W){offset_q[OFFSET_W-1]}}, offset_q};
      off_sh   = thumb_q ? (off_ext << 1) : (off_ext << 2);
      ret_addr = pc_q + step;
      if (thumb_q) begin
         ret_addr[0] = 1'b1;
      end
      if (!cond_q) begin
         target = pc_q + step;
      end else if (exch_q) begin
         target = rm_q & ~DATA_W'(1);
      end else begin
         target = pc_q + pf + off_sh;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand latch on acceptance, and capture of the two register reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cond_q   <= 1'b0;
         link_q   <= 1'b0;
         exch_q   <= 1'b0;
         thumb_q  <= 1'b0;
         offset_q <= '0;
         rm_idx_q <= '0;
         pc_q     <= '0;
         rm_q     <= '0;
      end else begin
         if (state_q == StIdle && start_i) begin
            cond_q   <= cond_i;
            link_q   <= link_i;
            exch_q   <= exchange_i;
            thumb_q  <= thumb_i;
            offset_q <= offset_i;
            rm_idx_q <= rm_i;
         end
         if (state_q == StWpc) begin
            pc_q <= read_value_i;
         end
         if (state_q == StWrm) begin
            rm_q <= read_value_i;
         end
      end
   end

   // Next-state sequencing; cond=0 skips the Rm read and the LR write.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start_i) state_d = StRpc;
         StRpc:  state_d = StWpc;
         StWpc: begin
            if (cond_q && exch_q) begin
               state_d = StRrm;
            end else if (cond_q && link_q) begin
               state_d = StWlr;
            end else begin
               state_d = StWrpc;
            end
         end
         StRrm:  state_d = StWrm;
         StWrm:  state_d = link_q ? StWlr : StWrpc;
         StWlr:  state_d = StWrpc;
         StWrpc: state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Moore output decode; everything is zero outside its own state.
   always_comb begin
      read_en_o     = 1'b0;
      read_reg_o    = '0;
      write_en_o    = 1'b0;
      write_reg_o   = '0;
      write_value_o = '0;
      t_we_o        = 1'b0;
      t_value_o     = 1'b0;
      busy_o        = (state_q != StIdle);
      done_o        = 1'b0;
      unique case (state_q)
         StRpc: begin
            read_en_o  = 1'b1;
            read_reg_o = REG_AW'(PC_REG);
         end
         StRrm: begin
            read_en_o  = 1'b1;
            read_reg_o = rm_idx_q;
         end
         StWlr: begin
            write_en_o    = 1'b1;
            write_reg_o   = REG_AW'(LR_REG);
            write_value_o = ret_addr;
         end
         StWrpc: begin
            write_en_o    = 1'b1;
            write_reg_o   = REG_AW'(PC_REG);
            write_value_o = target;
            t_we_o        = taken_exch;
            t_value_o     = taken_exch & rm_q[0];
         end
         StDone: done_o = 1'b1;
         default: ;
      endcase
   end

endmodule
